// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART tx FIFO arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam logic [7:0] TAG_BASE = 8'hF0;
    localparam int         NREQ_MAX = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above start, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win,
    output logic          vld
);

    always_comb begin
        int j;
        j   = 0;
        win = '0;
        vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!vld && req[j]) begin
                win[j] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART tx FIFO write port.
// Define UART_ARB_TAG_EN to prefix each packet with a 0xF0|owner header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0][7:0] req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [7:0]           fifo_wdata,
    output logic [NREQ-1:0]      grant,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      state, nxt_state;
    logic [IW-1:0]   owner, nxt_owner;
    logic [IW-1:0]   last_owner, nxt_last;
    logic [NREQ-1:0] nxt_grant;
    logic [IW-1:0]   start;
    logic [NREQ-1:0] pick_oh;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    assign start = (last_owner == IW'(NREQ - 1)) ? '0 : last_owner + 1'b1;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .start (start),
        .win   (pick_oh),
        .vld   (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick_oh[i]) pick_idx = IW'(i);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            grant      <= '0;
        end else begin
            state      <= nxt_state;
            owner      <= nxt_owner;
            last_owner <= nxt_last;
            grant      <= nxt_grant;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_owner  = owner;
        nxt_last   = last_owner;
        nxt_grant  = grant;
        fifo_wr    = 1'b0;
        fifo_wdata = 8'h00;
        req_ready  = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    nxt_owner = pick_idx;
                    nxt_grant = pick_oh;
`ifdef UART_ARB_TAG_EN
                    nxt_state = TAG;
`else
                    nxt_state = XFER;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                fifo_wdata = TAG_BASE | 8'(owner);
                fifo_wr    = ~fifo_full;
                if (!fifo_full) nxt_state = XFER;
            end
`endif
            XFER: begin
                // Owner keeps the FIFO through valid gaps until its last byte lands.
                fifo_wdata       = req_data[owner];
                fifo_wr          = req_valid[owner] & ~fifo_full;
                req_ready[owner] = fifo_wr;
                if (fifo_wr && req_last[owner]) begin
                    nxt_last  = owner;
                    nxt_grant = '0;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: packet-level round-robin model feeds an expected byte queue.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NREQ = 4;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic                 HCLK = 1'b0;
    logic                 HRESETn;
    logic [NREQ-1:0]      req_valid, req_last, req_ready, grant;
    logic [NREQ-1:0][7:0] req_data;
    logic                 fifo_full, fifo_wr, busy;
    logic [7:0]           fifo_wdata;

    always #5 HCLK = ~HCLK;

    uart_tx_arbiter #(.NREQ(NREQ)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .grant      (grant),
        .busy       (busy)
    );

    int         n_cmp = 0, n_err = 0;
    logic [8:0] stream[NREQ][$];   // {last, byte} still to be offered by each requester
    logic [8:0] mq[NREQ][$];       // same packets, consumed by the reference model
    logic [7:0] expq[$];
    bit         mid[NREQ];
    int         hold[NREQ];
    int         acc_cnt[NREQ];
    int         mlast = NREQ - 1;
    int         ff_mode = 0;       // 0 never full, 1 always full, 2 random
    bit         rnd_gap = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (expq.size() != 0);
        for (int i = 0; i < NREQ; i++) if (stream[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        logic [8:0] h;
        bit v;
        for (int i = 0; i < NREQ; i++) begin
            v = (stream[i].size() != 0);
            h = v ? stream[i][0] : 9'h0;
            if (v && mid[i] && hold[i] > 0) begin
                v = 1'b0;
                hold[i]--;
            end else if (v && mid[i] && rnd_gap && $urandom_range(3) == 0) begin
                v = 1'b0;
            end
            req_valid[i] = v;
            req_data[i]  = h[7:0];
            req_last[i]  = h[8];
        end
        fifo_full = (ff_mode == 1) ? 1'b1 : (ff_mode == 2) ? ($urandom_range(2) == 0) : 1'b0;
    endtask

    task automatic step();
        logic [NREQ-1:0] acc;
        logic [8:0] w;
        @(negedge HCLK);
        acc = req_ready;
        @(posedge HCLK);
        #1;
        if (HRESETn)
            for (int i = 0; i < NREQ; i++)
                if (acc[i] && stream[i].size() != 0) begin
                    w = stream[i].pop_front();
                    mid[i] = !w[8];
                    acc_cnt[i]++;
                end
        drive();
    endtask

    task automatic add_pkt(input int i, input int len, input logic [7:0] b0, input bit rnd);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = rnd ? 8'($urandom) : b0 + 8'(k);
            stream[i].push_back({k == len - 1, b});
            mq[i].push_back({k == len - 1, b});
        end
    endtask

    // Serve whole packets round-robin starting after the previous owner.
    task automatic run_model();
        int f;
        logic [8:0] w;
        forever begin
            f = -1;
            for (int k = 1; k <= NREQ; k++)
                if (f < 0 && mq[(mlast + k) % NREQ].size() != 0) f = (mlast + k) % NREQ;
            if (f < 0) break;
            if (TAG_ON) expq.push_back(TAG_BASE | 8'(f));
            do begin
                w = mq[f].pop_front();
                expq.push_back(w[7:0]);
            end while (!w[8]);
            mlast = f;
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < NREQ; i++) begin
            stream[i].delete();
            mq[i].delete();
            mid[i]  = 1'b0;
            hold[i] = 0;
        end
        expq.delete();
        mlast = NREQ - 1;
    endtask

    task automatic drain(input string nm, input int max);
        int c = 0;
        while (pending() && c < max) begin
            step();
            c++;
        end
        chk({nm, "_left"}, expq.size(), 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    always @(negedge HCLK) begin
        if (HRESETn === 1'b1) begin
            if (fifo_wr) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_wr: got %0h expected no write", fifo_wdata);
                end else begin
                    chk("wdata", fifo_wdata, expq.pop_front());
                end
            end
            chk("grant_onehot0", $onehot0(grant), 1);
            chk("busy_vs_grant", busy, |grant);
            chk("ready_outside_grant", req_ready & ~grant, 0);
            chk("ready_without_wr", (|req_ready) & ~fifo_wr, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    initial begin
        int base;
        int c;
        HRESETn = 1'b0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        clr_model();
        drive();
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wdata", fifo_wdata, 0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // single requester, three bytes on back-to-back cycles
        add_pkt(0, 3, 8'h41, 1'b0);
        run_model();
        drive();
        step();
        chk("single_grant", grant, 4'b0001);
        chk("single_busy", busy, 1);
        repeat (TAG_ON ? 3 : 2) step();
        chk("single_busy_last", busy, 1);
        step();
        chk("single_idle", busy, 0);
        chk("single_left", expq.size(), 0);

        // contention from reset: 0 then 2, and 0 again next round
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        clr_model();
        drive();
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        add_pkt(0, 2, 8'hA0, 1'b0);
        add_pkt(2, 2, 8'hC0, 1'b0);
        run_model();
        drive();
        step();
        chk("cont_grant0", grant, 4'b0001);
        drain("cont1", 50);
        add_pkt(0, 2, 8'hA8, 1'b0);
        add_pkt(2, 2, 8'hC8, 1'b0);
        run_model();
        drive();
        step();
        chk("cont_regrant0", grant, 4'b0001);
        drain("cont2", 50);

        // backpressure: five full cycles after the first data byte
        add_pkt(1, 4, 8'h00, 1'b1);
        run_model();
        drive();
        base = acc_cnt[1];
        repeat (TAG_ON ? 3 : 2) step();
        ff_mode   = 1;
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_no_wr", fifo_wr, 0);
            chk("bp_no_ready", req_ready, 0);
            if (k == 4) ff_mode = 0;
            step();
        end
        chk("bp_accepted", acc_cnt[1] - base, 1);
        #1;
        chk("bp_resume_wr", fifo_wr, 1);
        drain("bp", 50);

        // owner gap: requester 0 idles 3 cycles mid-packet while 1 waits
        add_pkt(0, 4, 8'h00, 1'b1);
        add_pkt(1, 2, 8'h00, 1'b1);
        run_model();
        drive();
        repeat (TAG_ON ? 3 : 2) step();
        hold[0] = 3;
        drive();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("gap_grant", grant, 4'b0001);
            chk("gap_no_ready", req_ready, 0);
            chk("gap_no_wr", fifo_wr, 0);
            step();
        end
        drain("gap", 50);

        // reset after two of four bytes
        add_pkt(2, 4, 8'h00, 1'b1);
        run_model();
        drive();
        base = acc_cnt[2];
        c = 0;
        while (acc_cnt[2] - base < 2 && c < 20) begin
            step();
            c++;
        end
        chk("rstmid_reached", acc_cnt[2] - base, 2);
        HRESETn = 1'b0;
        #1;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_wr", fifo_wr, 0);
        clr_model();
        drive();
        @(negedge HCLK) HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        add_pkt(1, 2, 8'h00, 1'b1);
        add_pkt(0, 1, 8'h00, 1'b1);
        run_model();
        drive();
        step();
        chk("rstmid_prio0", grant, 4'b0001);
        drain("rstmid", 50);

        // one-byte packet from requester 3
        add_pkt(3, 1, 8'h55, 1'b0);
        run_model();
        drive();
        drain("single_byte", 20);

        // randomized rounds with FIFO backpressure and owner gaps
        ff_mode = 2;
        rnd_gap = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(2);
                for (int p = 0; p < n; p++) add_pkt(i, $urandom_range(4, 1), 8'h00, 1'b1);
            end
            run_model();
            drive();
            drain("rand", 600);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
